// File: rtl/sysctrl_gen.sv
// MCU system-control endpoint: framed command decoder, LEDs, RGB, buttons, config slots, IRQs.
// Define SYSCTRL_IRQ_MASK_EN to add CMD7 (writable interrupt mask); otherwise the mask is fixed all ones.
module sysctrl_gen #(
    parameter logic [7:0] CORE_ID = 8'h01,
    parameter int         NUM_LED = 2,
    parameter int         NUM_BTN = 2,
    parameter int         INT_CH  = 8,
    parameter int         NUM_CFG = 26
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 data_in_strobe,
    input  logic                 data_in_start,
    input  logic [7:0]           data_in,
    output logic [7:0]           data_out,
    output logic                 int_out_n,
    input  logic [INT_CH-1:0]    int_in,
    output logic [INT_CH-1:0]    int_ack,
    input  logic [NUM_BTN-1:0]   buttons,
    output logic [NUM_LED-1:0]   leds,
    output logic [23:0]          color,
    output logic [8*NUM_CFG-1:0] cfg_values,
    output logic                 cfg_wr,
    output logic [4:0]           cfg_wr_idx
);

    localparam int              SLOT_W    = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;
    localparam logic [7:0]      ID_BASE   = 8'h41;
    localparam logic [INT_CH-1:0] EVT_CHANS = {{(INT_CH-1){1'b1}}, 1'b0};

    logic [3:0]          r_state;
    logic [7:0]          r_cmd;
    logic [7:0]          r_slot;
    logic [7:0]          r_data_out;
    logic [NUM_LED-1:0]  r_leds;
    logic [23:0]         r_color;
    logic [7:0]          r_cfg [NUM_CFG];
    logic                r_cfg_wr;
    logic [4:0]          r_cfg_wr_idx;
    logic [INT_CH-1:0]   r_pending;
    logic [INT_CH-1:0]   r_int_prev;
    logic [INT_CH-1:0]   r_int_ack;
    logic                r_int_out_n;

    logic                w_exec;
    logic                w_slot_ok;
    logic [INT_CH-1:0]   w_rise;
    logic [INT_CH-1:0]   w_clr;
    logic [INT_CH-1:0]   w_mask;

`ifdef SYSCTRL_IRQ_MASK_EN
    logic [INT_CH-1:0]   r_mask;
    assign w_mask = r_mask;
`else
    assign w_mask = '1;
`endif

    function automatic logic [7:0] bitrev(input logic [7:0] b);
        logic [7:0] res;
        for (int i = 0; i < 8; i++) begin
            res[i] = b[7-i];
        end
        return res;
    endfunction

    assign w_exec    = data_in_strobe && !data_in_start && (r_state != 4'd0);
    assign w_slot_ok = (r_slot < 8'(NUM_CFG));
    // ch0 is the coldboot flag: only reset sets it, so its line is never edge-detected
    assign w_rise    = int_in & ~r_int_prev & EVT_CHANS;
    assign w_clr     = (w_exec && r_cmd == 8'h05 && r_state == 4'd1) ? data_in[INT_CH-1:0] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= 4'd0;
            r_cmd        <= 8'h00;
            r_slot       <= 8'h00;
            r_data_out   <= 8'h00;
            r_leds       <= '0;
            r_color      <= 24'h000000;
            r_cfg_wr     <= 1'b0;
            r_cfg_wr_idx <= 5'd0;
            r_pending    <= INT_CH'(1);
            r_int_prev   <= '0;
            r_int_ack    <= '0;
            r_int_out_n  <= 1'b0;
            for (int i = 0; i < NUM_CFG; i++) begin
                r_cfg[i] <= 8'h00;
            end
`ifdef SYSCTRL_IRQ_MASK_EN
            r_mask       <= '1;
`endif
        end else begin
            r_cfg_wr    <= 1'b0;
            r_int_prev  <= int_in;
            // a new edge in the same cycle as an MCU clear keeps the bit pending
            r_pending   <= (r_pending & ~w_clr) | w_rise;
            r_int_ack   <= w_clr;
            r_int_out_n <= ~|(r_pending & w_mask);

            if (data_in_strobe && data_in_start) begin
                r_cmd   <= data_in;
                r_state <= 4'd1;
            end else if (w_exec) begin
                r_state <= (r_state == 4'hF) ? r_state : r_state + 4'd1;
                case (r_cmd)
                    8'h00: begin
                        case (r_state)
                            4'd1:    r_data_out <= 8'h5C;
                            4'd2:    r_data_out <= 8'h42;
                            4'd3:    r_data_out <= CORE_ID;
                            default: r_data_out <= 8'h00;
                        endcase
                    end
                    8'h01: if (r_state == 4'd1) r_leds <= data_in[NUM_LED-1:0];
                    8'h02: begin
                        case (r_state)
                            4'd1:    r_color[15:8]  <= bitrev(data_in);
                            4'd2:    r_color[7:0]   <= bitrev(data_in);
                            4'd3:    r_color[23:16] <= bitrev(data_in);
                            default: ;
                        endcase
                    end
                    8'h03: r_data_out <= 8'(buttons);
                    8'h04: begin
                        // ids below "A" wrap to large values and fail the range check
                        if (r_state == 4'd1) begin
                            r_slot <= data_in - ID_BASE;
                        end else if (r_state == 4'd2 && w_slot_ok) begin
                            r_cfg[r_slot[SLOT_W-1:0]] <= data_in;
                            r_cfg_wr                  <= 1'b1;
                            r_cfg_wr_idx              <= r_slot[4:0];
                        end
                    end
                    8'h05: r_data_out <= 8'(r_pending);
                    8'h06: begin
                        if (r_state == 4'd1) begin
                            r_slot <= data_in - ID_BASE;
                        end else if (w_slot_ok) begin
                            r_data_out <= r_cfg[r_slot[SLOT_W-1:0]];
                            r_slot     <= r_slot + 8'd1;
                        end else begin
                            r_data_out <= 8'h00;
                        end
                    end
`ifdef SYSCTRL_IRQ_MASK_EN
                    8'h07: begin
                        if (r_state == 4'd1) begin
                            r_mask     <= data_in[INT_CH-1:0];
                            r_data_out <= 8'(r_mask);
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CFG; gi++) begin : g_cfg_out
            assign cfg_values[8*gi +: 8] = r_cfg[gi];
        end
    endgenerate

    assign data_out   = r_data_out;
    assign int_out_n  = r_int_out_n;
    assign int_ack    = r_int_ack;
    assign leds       = r_leds;
    assign color      = r_color;
    assign cfg_wr     = r_cfg_wr;
    assign cfg_wr_idx = r_cfg_wr_idx;

endmodule

// File: tb/tb_sysctrl_gen.sv
// Bench for sysctrl_gen: directed frames plus random frames checked against a frame-level model.
// Exercises CMD7 mask behaviour when SYSCTRL_IRQ_MASK_EN is defined.
module tb_sysctrl_gen;

    localparam logic [7:0] CORE_ID = 8'h01;
    localparam int NUM_LED = 2;
    localparam int NUM_BTN = 2;
    localparam int INT_CH  = 8;
    localparam int NUM_CFG = 26;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         data_in_strobe = 1'b0;
    logic         data_in_start = 1'b0;
    logic [7:0]   data_in = 8'h00;
    logic [7:0]   data_out;
    logic         int_out_n;
    logic [7:0]   int_in = 8'h00;
    logic [7:0]   int_ack;
    logic [1:0]   buttons = 2'b00;
    logic [1:0]   leds;
    logic [23:0]  color;
    logic [207:0] cfg_values;
    logic         cfg_wr;
    logic [4:0]   cfg_wr_idx;

    sysctrl_gen #(
        .CORE_ID(CORE_ID), .NUM_LED(NUM_LED), .NUM_BTN(NUM_BTN),
        .INT_CH(INT_CH), .NUM_CFG(NUM_CFG)
    ) dut (
        .clk(clk), .reset(reset),
        .data_in_strobe(data_in_strobe), .data_in_start(data_in_start), .data_in(data_in),
        .data_out(data_out), .int_out_n(int_out_n), .int_in(int_in), .int_ack(int_ack),
        .buttons(buttons), .leds(leds), .color(color), .cfg_values(cfg_values),
        .cfg_wr(cfg_wr), .cfg_wr_idx(cfg_wr_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state, expressed as frame position and plain integer slot ids
    logic [7:0]  m_cmd, m_dout, m_pend, m_prev, m_mask, m_ack;
    logic [1:0]  m_leds;
    logic [23:0] m_color;
    logic [7:0]  m_cfg [NUM_CFG];
    logic        m_wr, m_ion;
    logic [4:0]  m_wr_idx;
    int          m_pos, m_id, m_rd;
    logic [7:0]  irq = 8'h00;

    task automatic check(input string tag, input logic [207:0] act, input logic [207:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cmd = 8'h00; m_dout = 8'h00; m_pend = 8'h01; m_prev = 8'h00; m_mask = 8'hFF;
        m_ack = 8'h00; m_leds = 2'b00; m_color = 24'h0; m_wr = 1'b0; m_ion = 1'b0;
        m_wr_idx = 5'd0; m_pos = 0; m_id = 0; m_rd = 0;
        for (int i = 0; i < NUM_CFG; i++) m_cfg[i] = 8'h00;
    endtask

    task automatic model_step(input bit stb, input bit st, input logic [7:0] d, input logic [7:0] irq_now);
        logic [7:0] old_pend, clr, rise, rev;
        old_pend = m_pend;
        clr      = 8'h00;
        rise     = irq_now & ~m_prev & 8'hFE;
        m_prev   = irq_now;
        m_ion    = ~|(old_pend & m_mask);
        m_wr     = 1'b0;
        rev      = {<<{d}};
        if (stb && st) begin
            m_cmd = d;
            m_pos = 1;
        end else if (stb && m_pos > 0) begin
            case (m_cmd)
                8'h00: m_dout = (m_pos == 1) ? 8'h5C : (m_pos == 2) ? 8'h42 : (m_pos == 3) ? CORE_ID : 8'h00;
                8'h01: if (m_pos == 1) m_leds = d[1:0];
                8'h02: begin
                    if (m_pos == 1) m_color[15:8]  = rev;
                    if (m_pos == 2) m_color[7:0]   = rev;
                    if (m_pos == 3) m_color[23:16] = rev;
                end
                8'h03: m_dout = {6'b0, buttons};
                8'h04: begin
                    if (m_pos == 1) m_id = int'(d) - 65;
                    else if (m_pos == 2 && m_id >= 0 && m_id < NUM_CFG) begin
                        m_cfg[m_id] = d;
                        m_wr        = 1'b1;
                        m_wr_idx    = 5'(m_id);
                    end
                end
                8'h05: begin
                    m_dout = old_pend;
                    if (m_pos == 1) clr = d;
                end
                8'h06: begin
                    if (m_pos == 1) m_rd = int'(d) - 65;
                    else begin
                        m_dout = (m_rd >= 0 && m_rd < NUM_CFG) ? m_cfg[m_rd] : 8'h00;
                        m_rd++;
                    end
                end
`ifdef SYSCTRL_IRQ_MASK_EN
                8'h07: if (m_pos == 1) begin
                    m_dout = m_mask;
                    m_mask = d;
                end
`endif
                default: ;
            endcase
            m_pos++;
        end
        m_pend = (old_pend & ~clr) | rise;
        m_ack  = clr;
    endtask

    task automatic compare_all();
        logic [207:0] flat;
        for (int i = 0; i < NUM_CFG; i++) flat[8*i +: 8] = m_cfg[i];
        check("data_out",   data_out,   m_dout);
        check("leds",       leds,       m_leds);
        check("color",      color,      m_color);
        check("cfg_values", cfg_values, flat);
        check("cfg_wr",     cfg_wr,     m_wr);
        if (m_wr) check("cfg_wr_idx", cfg_wr_idx, m_wr_idx);
        check("int_ack",    int_ack,    m_ack);
        check("int_out_n",  int_out_n,  m_ion);
    endtask

    // one clock: drive at negedge, advance model, sample at the following negedge
    task automatic cycle(input bit stb, input bit st, input logic [7:0] d);
        data_in_strobe = stb;
        data_in_start  = st;
        data_in        = d;
        int_in         = irq;
        buttons        = 2'($urandom_range(0, 3));
        model_step(stb, st, d, irq);
        @(negedge clk);
        data_in_strobe = 1'b0;
        data_in_start  = 1'b0;
        compare_all();
        if (stb)
            $display("byte start=%0b data=%02h -> data_out=%02h int_out_n=%0b int_ack=%02h cfg_wr=%0b",
                     st, d, data_out, int_out_n, int_ack, cfg_wr);
    endtask

    task automatic do_reset();
        @(negedge clk);
        irq = 8'h00;
        int_in = 8'h00;
        data_in_strobe = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_data_out",  data_out,   8'h00);
        check("rst_leds",      leds,       2'b00);
        check("rst_color",     color,      24'h0);
        check("rst_cfg",       cfg_values, 208'h0);
        check("rst_cfg_wr",    cfg_wr,     1'b0);
        check("rst_int_ack",   int_ack,    8'h00);
        check("rst_int_out_n", int_out_n,  1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        logic [7:0] cmd_pool [10];
        logic [7:0] cmd, d;
        int len;
        cmd_pool = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09, 8'hA5};
        model_reset();
        do_reset();

        cycle(1, 0, 8'h77);                       // payload while idle is ignored
        check("idle_ignored", data_out, 8'h00);

        cycle(1, 1, 8'h00);
        cycle(1, 0, 8'h11); check("id_b1", data_out, 8'h5C);
        cycle(1, 0, 8'h22); check("id_b2", data_out, 8'h42);
        cycle(1, 0, 8'h33); check("id_b3", data_out, CORE_ID);
        check("coldboot_irq", int_out_n, 1'b0);
        cycle(1, 0, 8'h44); check("id_b4", data_out, 8'h00);

        cycle(1, 1, 8'h05);
        cycle(1, 0, 8'h01); check("ack_coldboot", int_ack, 8'h01);
        idle(1);            check("irq_released", int_out_n, 1'b1);
        check("ack_one_cycle", int_ack, 8'h00);

        cycle(1, 1, 8'h04); cycle(1, 0, 8'h4D); cycle(1, 0, 8'h03);
        check("cfg_M_val", cfg_values[103:96], 8'h03);
        check("cfg_M_wr",  cfg_wr, 1'b1);
        check("cfg_M_idx", cfg_wr_idx, 5'd12);
        cycle(1, 1, 8'h04); cycle(1, 0, 8'h7A); cycle(1, 0, 8'h03);
        check("cfg_z_nowr", cfg_wr, 1'b0);

        cycle(1, 1, 8'h04); cycle(1, 0, 8'h59); cycle(1, 0, 8'h5A);
        cycle(1, 1, 8'h04); cycle(1, 0, 8'h5A); cycle(1, 0, 8'hA5);
        cycle(1, 1, 8'h06); cycle(1, 0, 8'h59);
        cycle(1, 0, 8'h00); check("rd_slot24", data_out, 8'h5A);
        cycle(1, 0, 8'h00); check("rd_slot25", data_out, 8'hA5);
        cycle(1, 0, 8'h00); check("rd_past_end", data_out, 8'h00);

        cycle(1, 1, 8'h02); cycle(1, 0, 8'h01); cycle(1, 0, 8'h02); cycle(1, 0, 8'h04);
        check("color_rev", color, 24'h208040);
        cycle(1, 1, 8'h01); cycle(1, 0, 8'hFE);
        check("leds_set", leds, 2'b10);

        cycle(1, 1, 8'h05);
        irq = 8'h08;
        cycle(1, 0, 8'h08);                       // edge and clear collide on ch3
        idle(1);            check("set_wins_irq", int_out_n, 1'b0);
        cycle(1, 1, 8'h05); cycle(1, 0, 8'h00); check("set_wins_pend", data_out, 8'h08);
        cycle(1, 1, 8'h05); cycle(1, 0, 8'h08);   // held-high line must not re-set
        idle(2);
        cycle(1, 1, 8'h05); cycle(1, 0, 8'h00); check("held_no_reset", data_out, 8'h00);
        check("held_irq_off", int_out_n, 1'b1);

`ifdef SYSCTRL_IRQ_MASK_EN
        cycle(1, 1, 8'h07); cycle(1, 0, 8'h00); check("mask_old", data_out, 8'hFF);
        irq = 8'h0C;
        idle(3);            check("masked_irq", int_out_n, 1'b1);
        cycle(1, 1, 8'h05); cycle(1, 0, 8'h00); check("masked_pend", data_out, 8'h04);
        cycle(1, 1, 8'h07); cycle(1, 0, 8'hFF); check("mask_old0", data_out, 8'h00);
        idle(2);            check("unmasked_irq", int_out_n, 1'b0);
`endif

        cycle(1, 1, 8'h01);                       // reset mid-frame returns to idle
        do_reset();
        cycle(1, 0, 8'h03); check("post_rst_idle", leds, 2'b00);

        for (int f = 0; f < 60; f++) begin
            cmd = cmd_pool[$urandom_range(0, 9)];
            cycle(1, 1, cmd);
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 3) == 0) irq = irq ^ (8'h01 << $urandom_range(0, 7));
                if (b == 0 && (cmd == 8'h04 || cmd == 8'h06) && $urandom_range(0, 2) != 0)
                    d = 8'(65 + $urandom_range(0, 27));
                else
                    d = 8'($urandom);
                cycle(1, 0, d);
                if ($urandom_range(0, 2) == 0) idle(1);
            end
        end
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
